// File: rtl/sub_and_mul_arbiter.sv
// sub_and_mul_arbiter: round-robin sharing of one sub_and_mul datapath (A - 2*B) between two clients
// Ports:
//   i_clk, i_rsn                     clock, async active-low reset
//   i_reqN, i_arg_AN, i_arg_BN       client N request and signed operands
//   o_gntN                           one-cycle grant pulse, operands latched
//   o_doneN, o_resN, o_statN, i_ackN registered response held until ack
//   o_dp_A, o_dp_B                   operands to the shared datapath
//   i_dp_result, i_dp_status         datapath response
//   o_ovf_cnt                        saturating overflow-response count
module sub_and_mul_arbiter #(
  parameter int M = 8,
  parameter int K = 8
) (
  input  logic         i_clk,
  input  logic         i_rsn,
  input  logic         i_req0,
  input  logic         i_req1,
  input  logic [M-1:0] i_arg_A0,
  input  logic [M-1:0] i_arg_A1,
  input  logic [M-1:0] i_arg_B0,
  input  logic [M-1:0] i_arg_B1,
  output logic         o_gnt0,
  output logic         o_gnt1,
  output logic         o_done0,
  output logic         o_done1,
  output logic [K-1:0] o_res0,
  output logic [K-1:0] o_res1,
  output logic [3:0]   o_stat0,
  output logic [3:0]   o_stat1,
  input  logic         i_ack0,
  input  logic         i_ack1,
  output logic [M-1:0] o_dp_A,
  output logic [M-1:0] o_dp_B,
  input  logic [K-1:0] i_dp_result,
  input  logic [3:0]   i_dp_status,
  output logic [7:0]   o_ovf_cnt
);
  typedef enum logic [1:0] {IDLE, EXEC, WAIT} state_t;
  state_t state_q, state_d;
  logic ptr_q, ptr_d, win_q, win_d;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, done0_q, done0_d, done1_q, done1_d;
  logic [M-1:0] a_q, a_d, b_q, b_d;
  logic [K-1:0] res0_q, res0_d, res1_q, res1_d, res_cap;
  logic [3:0] stat0_q, stat0_d, stat1_q, stat1_d;
  logic [7:0] cnt_q, cnt_d;
  logic sel1, ovf;
  // client 1 wins unless client 0 requests and either is alone or client 1 won last
  assign sel1 = ~(i_req0 & (~i_req1 | ptr_q));
  assign ovf = i_dp_status == 4'b1001;
  // an overflowing datapath result may be undefined, so it is never stored
  assign res_cap = ovf ? '0 : i_dp_result;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    win_d = win_q;
    a_d = a_q;
    b_d = b_q;
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    done0_d = done0_q;
    done1_d = done1_q;
    res0_d = res0_q;
    res1_d = res1_q;
    stat0_d = stat0_q;
    stat1_d = stat1_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (i_req0 | i_req1) begin
        win_d = sel1;
        ptr_d = sel1;
        a_d = sel1 ? i_arg_A1 : i_arg_A0;
        b_d = sel1 ? i_arg_B1 : i_arg_B0;
        gnt0_d = ~sel1;
        gnt1_d = sel1;
        state_d = EXEC;
      end
      EXEC: begin
        if (win_q) begin
          res1_d = res_cap;
          stat1_d = i_dp_status;
          done1_d = 1'b1;
        end else begin
          res0_d = res_cap;
          stat0_d = i_dp_status;
          done0_d = 1'b1;
        end
        cnt_d = (ovf && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
        state_d = WAIT;
      end
      WAIT: if (win_q ? i_ack1 : i_ack0) begin
        done0_d = 1'b0;
        done1_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      state_q <= IDLE;
      ptr_q <= 1'b1;
      win_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      res0_q <= '0;
      res1_q <= '0;
      stat0_q <= '0;
      stat1_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      a_q <= a_d;
      b_q <= b_d;
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      res0_q <= res0_d;
      res1_q <= res1_d;
      stat0_q <= stat0_d;
      stat1_q <= stat1_d;
      cnt_q <= cnt_d;
    end
  end
  assign o_gnt0 = gnt0_q;
  assign o_gnt1 = gnt1_q;
  assign o_done0 = done0_q;
  assign o_done1 = done1_q;
  assign o_res0 = res0_q;
  assign o_res1 = res1_q;
  assign o_stat0 = stat0_q;
  assign o_stat1 = stat1_q;
  assign o_dp_A = a_q;
  assign o_dp_B = b_q;
  assign o_ovf_cnt = cnt_q;
endmodule

// File: tb/tb_sub_and_mul_arbiter.sv
// tb_sub_and_mul_arbiter: scoreboard bench for the two-client sub_and_mul arbiter
module tb_sub_and_mul_arbiter;
  logic i_clk = 1'b0, i_rsn = 1'b0;
  logic i_req0 = 1'b0, i_req1 = 1'b0, i_ack0 = 1'b0, i_ack1 = 1'b0;
  logic [7:0] i_arg_A0 = '0, i_arg_A1 = '0, i_arg_B0 = '0, i_arg_B1 = '0;
  logic o_gnt0, o_gnt1, o_done0, o_done1;
  logic [7:0] o_res0, o_res1, o_dp_A, o_dp_B, i_dp_result, o_ovf_cnt;
  logic [3:0] o_stat0, o_stat1, i_dp_status;
  int checks = 0, errors = 0, w;
  logic pd0 = 1'b0, pd1 = 1'b0;
  typedef struct {bit c; logic [7:0] r; logic [3:0] s;} exp_t;
  exp_t q[$];

  always #5 i_clk = ~i_clk;

  sub_and_mul_arbiter #(.M(8), .K(8)) dut (
    .i_clk(i_clk), .i_rsn(i_rsn), .i_req0(i_req0), .i_req1(i_req1),
    .i_arg_A0(i_arg_A0), .i_arg_A1(i_arg_A1), .i_arg_B0(i_arg_B0), .i_arg_B1(i_arg_B1),
    .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_done0(o_done0), .o_done1(o_done1),
    .o_res0(o_res0), .o_res1(o_res1), .o_stat0(o_stat0), .o_stat1(o_stat1),
    .i_ack0(i_ack0), .i_ack1(i_ack1), .o_dp_A(o_dp_A), .o_dp_B(o_dp_B),
    .i_dp_result(i_dp_result), .i_dp_status(i_dp_status), .o_ovf_cnt(o_ovf_cnt)
  );

  // shared datapath: A - 2*B, wrapped low byte on overflow so only a zeroing DUT matches
  always_comb begin
    w = $signed(o_dp_A) - 2 * $signed(o_dp_B);
    i_dp_status = (w > 127 || w < -128) ? 4'b1001 : 4'b0000;
    i_dp_result = w[7:0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop(input bit c, input logic [7:0] r, input logic [3:0] s);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: client %0d res %0h stat %0h with nothing expected", c, r, s);
    end else begin
      e = q.pop_front();
      check("resp_client", c, e.c);
      check("resp_res", r, e.r);
      check("resp_stat", s, e.s);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_done0 && !pd0) pop(1'b0, o_res0, o_stat0);
    if (o_done1 && !pd1) pop(1'b1, o_res1, o_stat1);
    pd0 <= o_done0;
    pd1 <= o_done1;
  end

  task automatic wait_done(input bit c);
    @(negedge i_clk);
    check("gnt_pulse", c ? o_gnt1 : o_gnt0, 0);
    for (int i = 0; i < 8 && !(c ? o_done1 : o_done0); i++) @(negedge i_clk);
    checks++;
    if (!(c ? o_done1 : o_done0)) begin
      errors++;
      $display("FAIL done_timeout: client %0d done got 0 expected 1", c);
    end
  endtask

  task automatic run1(input bit c, input logic [7:0] a, b, r, input logic [3:0] s);
    if (c) begin i_req1 = 1'b1; i_arg_A1 = a; i_arg_B1 = b; end
    else begin i_req0 = 1'b1; i_arg_A0 = a; i_arg_B0 = b; end
    q.push_back('{c, r, s});
    @(negedge i_clk);
    check("gnt", c ? o_gnt1 : o_gnt0, 1);
    check("gnt_other", c ? o_gnt0 : o_gnt1, 0);
    check("dp_A", o_dp_A, a);
    check("dp_B", o_dp_B, b);
    i_req0 = 1'b0;
    i_req1 = 1'b0;
    wait_done(c);
    if (c) i_ack1 = 1'b1; else i_ack0 = 1'b1;
    @(negedge i_clk);
    i_ack0 = 1'b0;
    i_ack1 = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    check("rst_gnt", {o_gnt0, o_gnt1, o_done0, o_done1}, 0);
    check("rst_res", {o_res0, o_res1, o_stat0, o_stat1}, 0);
    check("rst_dp", {o_dp_A, o_dp_B, o_ovf_cnt}, 0);
    i_rsn = 1'b1;
    @(negedge i_clk);
    // single op and overflow
    run1(1'b0, 8'd10, 8'd3, 8'h04, 4'b0000);
    check("ovf_cnt_single", o_ovf_cnt, 0);
    run1(1'b1, 8'h9C, 8'h28, 8'h00, 4'b1001);
    check("ovf_cnt_one", o_ovf_cnt, 1);
    check("res0_kept", o_res0, 8'h04);
    // contention with immediate acks: 0,1,0,1
    i_arg_A0 = 8'd20; i_arg_B0 = 8'd5; i_arg_A1 = 8'hFB; i_arg_B1 = 8'hF6;
    for (int k = 0; k < 4; k++) q.push_back('{k[0], k[0] ? 8'd15 : 8'd10, 4'b0000});
    i_req0 = 1'b1; i_req1 = 1'b1; i_ack0 = 1'b1; i_ack1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      for (int i = 0; i < 10 && !(o_gnt0 | o_gnt1); i++) @(negedge i_clk);
      check("contention_gnt0", o_gnt0, k % 2 == 0);
      check("contention_gnt1", o_gnt1, k % 2 == 1);
      if (k == 3) begin i_req0 = 1'b0; i_req1 = 1'b0; end
    end
    repeat (2) @(negedge i_clk);
    i_ack0 = 1'b0; i_ack1 = 1'b0;
    // held response with delayed ack, stray ack1, pending req1
    i_req0 = 1'b1; i_arg_A0 = 8'd1; i_arg_B0 = 8'd1;
    q.push_back('{1'b0, 8'hFF, 4'b0000});
    @(negedge i_clk);
    check("held_gnt0", o_gnt0, 1);
    i_req0 = 1'b0;
    @(negedge i_clk);
    i_req1 = 1'b1; i_arg_A1 = 8'hFB; i_arg_B1 = 8'hF6; i_ack1 = 1'b1;
    q.push_back('{1'b1, 8'd15, 4'b0000});
    repeat (5) begin
      @(negedge i_clk);
      check("held_done0", o_done0, 1);
      check("held_res0", o_res0, 8'hFF);
      check("held_stat0", o_stat0, 0);
      check("held_no_gnt1", o_gnt1, 0);
    end
    i_ack0 = 1'b1;
    @(negedge i_clk);
    i_ack0 = 1'b0;
    check("ack_done0_clear", o_done0, 0);
    check("ack_edge_no_gnt1", o_gnt1, 0);
    @(negedge i_clk);
    check("late_gnt1", o_gnt1, 1);
    i_req1 = 1'b0;
    repeat (2) @(negedge i_clk);
    i_ack1 = 1'b0;
    check("res0_after_other", o_res0, 8'hFF);
    // reset during EXEC
    i_req0 = 1'b1; i_arg_A0 = 8'd50; i_arg_B0 = 8'd10;
    @(negedge i_clk);
    check("abort_gnt0", o_gnt0, 1);
    i_req0 = 1'b0;
    i_rsn = 1'b0;
    #1;
    check("abort_ctl", {o_gnt0, o_gnt1, o_done0, o_done1}, 0);
    check("abort_res", {o_res0, o_res1, o_stat0, o_stat1}, 0);
    check("abort_dp", {o_dp_A, o_dp_B, o_ovf_cnt}, 0);
    @(negedge i_clk);
    i_rsn = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      check("abort_no_done", {o_done0, o_done1}, 0);
    end
    i_req0 = 1'b1; i_req1 = 1'b1; i_arg_A0 = 8'd20; i_arg_B0 = 8'd5;
    q.push_back('{1'b0, 8'd10, 4'b0000});
    @(negedge i_clk);
    check("post_rst_tie_gnt0", o_gnt0, 1);
    check("post_rst_tie_gnt1", o_gnt1, 0);
    i_req0 = 1'b0; i_req1 = 1'b0;
    wait_done(1'b0);
    i_ack0 = 1'b1;
    @(negedge i_clk);
    i_ack0 = 1'b0;
    // overflow counter saturation
    for (int i = 1; i <= 260; i++) begin
      run1(1'b0, 8'h80, 8'h01, 8'h00, 4'b1001);
      if (i == 254 || i == 255 || i == 260) check("ovf_cnt_sat", o_ovf_cnt, i > 255 ? 255 : i);
    end
    repeat (2) @(negedge i_clk);
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sub_and_mul_arbiter.md
# sub_and_mul_arbiter

Two-requester, round-robin scheduler that shares one combinational `sub_and_mul` datapath (result = A − 2·B, status 4'b1001 on signed overflow). It accepts operand pairs from two clients, issues one operation at a time to the datapath, and registers each client's result and status. It holds each response until that client acknowledges it, and keeps a saturating overflow count. It sits between the ALU front-end clients and the shared `sub_and_mul` instance.

## Interface
- M, 8, operand width (bits)
- K, 8, result width (bits); K == M

- i_clk  in  1  clock, rising-edge
- i_rsn  in  1  asynchronous active-low reset
- i_req0 / i_req1  in  1  operation request, client 0 / 1
- i_arg_A0 / i_arg_A1  in  M  operand A, client 0 / 1 (signed)
- i_arg_B0 / i_arg_B1  in  M  operand B, client 0 / 1 (signed)
- o_gnt0 / o_gnt1  out  1  one-cycle pulse: request accepted, operands latched
- o_done0 / o_done1  out  1  response valid, held until ack
- o_res0 / o_res1  out  K  registered result, client 0 / 1
- o_stat0 / o_stat1  out  4  registered status, client 0 / 1 (4'b0000 ok, 4'b1001 overflow)
- i_ack0 / i_ack1  in  1  response consumed, client 0 / 1
- o_dp_A  out  M  datapath operand A
- o_dp_B  out  M  datapath operand B
- i_dp_result  in  K  datapath result
- i_dp_status  in  4  datapath status
- o_ovf_cnt  out  8  saturating count of overflow responses

## Operation
- FSM states: IDLE, EXEC, WAIT. Reset state is IDLE.
- **IDLE:** if any i_reqN is high at an edge, arbitrate:
  - Winner's operands latch into the operand registers.
  - o_gntN goes high for exactly one cycle.
  - Winner index latches.
  - Next state is EXEC.
  - With no request, remain in IDLE.
- **Arbitration:** a single request wins outright. If both request, the client that did not win last wins. The last-winner pointer resets to 1, so client 0 wins the first tie. The pointer updates only on a grant.
- **EXEC** (exactly one cycle):
  - o_dp_A/o_dp_B present the latched operands.
  - At the closing edge, capture i_dp_status into o_statN of the winner. Capture i_dp_result into o_resN, or capture 0 when status is 4'b1001, so X is never propagated.
  - Set o_doneN to 1. Next state is WAIT.
- **WAIT:** o_doneN, o_resN and o_statN hold. When the winner's i_ackN is sampled high, clear o_doneN and go to IDLE.
- **Ack handling:** the other client's ack is ignored, and acks are ignored outside WAIT.
- **Losing requests:** requests are not queued; the losing request is simply still pending in the next IDLE. A client deasserts i_reqN after seeing o_gntN. A request seen outside IDLE is not sampled.
- **Idle response registers:** o_resN and o_statN of the non-winning client keep their previous values.
- **Datapath outputs:** o_dp_A/o_dp_B always drive the operand registers, which hold between operations.
- **Overflow counter:** o_ovf_cnt increments by 1 at each EXEC capture with status 4'b1001 and saturates at 255.

## Timing
- **Reset values:** all outputs 0 (o_gnt*, o_done*, o_res*, o_stat*, o_dp_A, o_dp_B, o_ovf_cnt), state IDLE, pointer = 1.
- **Reset mid-operation:** asserting i_rsn low at any time, including EXEC or WAIT, immediately aborts. No o_done is raised for the aborted operation.
- **Latency** (request sampled at edge t):
  - o_gnt is high in cycle t..t+1.
  - o_dp_A/o_dp_B are valid in the same cycle.
  - o_done, o_res and o_stat are valid from edge t+1.
- **Throughput:** with ack high in the first WAIT cycle, back-to-back requests are granted every 3 cycles (IDLE, EXEC, WAIT).
- **Delayed ack:** the datapath is not reused until the current response is acked. A late ack stalls both clients.
- **Simultaneous events:** an ack and a new request in the same WAIT cycle produce a return to IDLE. The new request is granted at the following edge, not the same one.

## Test plan
- **Single op:** client 0 sends A=10, B=3 → o_gnt0 pulses one cycle; one cycle later o_res0=4 (0x04), o_stat0=4'b0000, o_done0=1 until i_ack0; o_ovf_cnt=0.
- **Overflow:** client 1 sends A=−100 (0x9C), B=40 (0x28) → o_stat1=4'b1001, o_res1=0, o_ovf_cnt=1.
- **Contention:** both clients request continuously with immediate acks → grant order 0, 1, 0, 1. Each grant uses its own operands, e.g. A0=20, B0=5 → 10; A1=−5, B1=−10 → 15.
- **Held response:** ack for client 0 delayed 5 cycles while client 1 requests → o_done0, o_res0 and o_stat0 stable for 5 cycles. o_gnt1 is not asserted until the cycle after the ack-IDLE edge. A stray i_ack1 in WAIT has no effect.
- **Reset mid-EXEC:** i_rsn pulsed low during EXEC → all outputs 0 immediately, no o_done afterward. On the first tie after reset, client 0 is granted.
- **Counter saturation:** 260 overflow ops (A=0x80, B=0x01) → o_ovf_cnt reaches 255 and stays 255.
